ex_sequencer: RTL and testbench

EX_SEQUENCER -- requirements
Module: ex_sequencer

---
 rtl/ex_sequencer_pkg.sv | 42 ++++
 rtl/ex_sequencer_if.sv | 60 ++++++
 rtl/ex_latency_counter.sv | 35 +++
 rtl/ex_sequencer.sv | 135 +++++++++++++
 tb/tb_ex_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_sequencer_pkg.sv
// rtl/ex_sequencer_pkg.sv - shared opcode/state types and latency helper for the execute sequencer
// Purpose: opcode enum, sequencer state enum, highest legal opcode, and the
//          per-opcode latency-counter load value.
// Ports:   none (package).
package ex_sequencer_pkg;

  typedef enum logic [4:0] {
    OPC_NOP  = 5'd0,
    OPC_LV   = 5'd1,
    OPC_MLT  = 5'd2,
    OPC_DIV  = 5'd3,
    OPC_REST = 5'd4,
    OPC_SUM  = 5'd5,
    OPC_CP   = 5'd6,
    OPC_B    = 5'd7,
    OPC_BEG  = 5'd8,
    OPC_SLR  = 5'd9,
    OPC_GP   = 5'd10
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [4:0] OPC_MAX = 5'd10;

  // Counter value loaded on accept; zero means the result is ready one cycle later.
  function automatic logic [3:0] latency_load(input logic [4:0] opc,
                                              input logic [3:0] mlt_load,
                                              input logic [3:0] div_load);
    if (opc == OPC_DIV) return div_load;
    else if (opc == OPC_MLT) return mlt_load;
    else return 4'd0;
  endfunction

  function automatic logic is_legal(input logic [4:0] opc);
    return (opc <= OPC_MAX);
  endfunction

endpackage

// File: rtl/ex_sequencer_if.sv
// rtl/ex_sequencer_if.sv - instruction, ALU and writeback bundle of the execute sequencer
// Purpose: groups the upstream instruction handshake, the operand/result path to
//          the external combinational ALU, and the downstream writeback handshake.
// Ports (slave = sequencer side):
//   in_valid/in_ready, in_opcode[4:0], in_rd[6:0], in_rs/in_rsi/in_rt[31:0]   upstream
//   alu_opcode[4:0], alu_rd[9:0], alu_rs/alu_rsi/alu_rt[31:0]                  to ALU
//   alu_result[31:0], alu_rd_out[6:0], alu_branch[6:0], alu_wren               from ALU
//   out_valid/out_ready, out_result[31:0], out_rd[6:0], out_wren,
//   out_branch_taken, out_branch_target[6:0], out_illegal, out_divzero          downstream
interface ex_sequencer_if;

  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [6:0]  in_rd;
  logic [31:0] in_rs;
  logic [31:0] in_rsi;
  logic [31:0] in_rt;

  logic [4:0]  alu_opcode;
  logic [9:0]  alu_rd;
  logic [31:0] alu_rs;
  logic [31:0] alu_rsi;
  logic [31:0] alu_rt;
  logic [31:0] alu_result;
  logic [6:0]  alu_rd_out;
  logic [6:0]  alu_branch;
  logic        alu_wren;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [6:0]  out_rd;
  logic        out_wren;
  logic        out_branch_taken;
  logic [6:0]  out_branch_target;
  logic        out_illegal;
  logic        out_divzero;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs, in_rsi, in_rt,
    output in_ready,
    output alu_opcode, alu_rd, alu_rs, alu_rsi, alu_rt,
    input  alu_result, alu_rd_out, alu_branch, alu_wren,
    output out_valid, out_result, out_rd, out_wren,
    output out_branch_taken, out_branch_target, out_illegal, out_divzero,
    input  out_ready
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_rs, in_rsi, in_rt,
    input  in_ready,
    input  alu_opcode, alu_rd, alu_rs, alu_rsi, alu_rt,
    output alu_result, alu_rd_out, alu_branch, alu_wren,
    input  out_valid, out_result, out_rd, out_wren,
    input  out_branch_taken, out_branch_target, out_illegal, out_divzero,
    output out_ready
  );

endinterface

// File: rtl/ex_latency_counter.sv
// rtl/ex_latency_counter.sv - loadable 4-bit down-counter with last-cycle flag
// Purpose: counts the remaining execute cycles of a multi-cycle instruction.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous clear (highest priority)
//   load, load_val  load a new count
//   dec             decrement by one (saturates at zero)
//   last            count == 1, i.e. the next decrement finishes the instruction
module ex_latency_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       last
);

  logic [3:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else if (clr) begin
      count_q <= 4'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign last = (count_q == 4'd1);

endmodule

// File: rtl/ex_sequencer.sv
// rtl/ex_sequencer.sv - execute-stage sequencer around an external combinational ALU
// Purpose: accepts one instruction at a time, holds its operands for the ALU for
//          the opcode's latency, then presents the result until it is retired.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous abort of the in-flight instruction
//   bus         ex_sequencer_if.slave: instruction in, ALU operands/results, writeback out
// Parameters: MLT_CYCLES, DIV_CYCLES (1..15) accept-to-result latency of MLT and DIV.
module ex_sequencer
  import ex_sequencer_pkg::*;
#(
  parameter int MLT_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  ex_sequencer_if.slave bus
);

  localparam logic [3:0] MLT_LOAD = 4'(MLT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic        accept, retire;
  logic        cnt_load, cnt_dec, cnt_clr, cnt_last;
  logic [3:0]  load_val;

  logic [4:0]  opc_q;      // opcode as issued, kept for the error/branch flags
  logic [4:0]  alu_opc_q;  // opcode as seen by the ALU (NOP when idle or illegal)
  logic [6:0]  rd_q;
  logic [31:0] rs_q, rsi_q, rt_q;

  logic        done, illegal, divzero, is_branch;

  ex_latency_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (load_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // in_ready is masked by rst_n so nothing looks acceptable while reset is held.
  assign bus.in_ready = rst_n && !flush &&
                        ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    retire   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    load_val = latency_load(bus.in_opcode, MLT_LOAD, DIV_LOAD);
    if (flush) begin
      // flush wins over accept and retire
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: accept = bus.in_valid;
        ST_BUSY: begin
          cnt_dec = 1'b1;
          if (cnt_last) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            retire = 1'b1;
            accept = bus.in_valid;
            if (!bus.in_valid) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (accept) begin
        cnt_load = 1'b1;
        state_d  = (load_val == 4'd0) ? ST_DONE : ST_BUSY;
      end
    end
  end

  // Operand registers only change on accept; the ALU opcode drops to NOP
  // whenever the sequencer goes idle so the ALU sees no stale instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q     <= 5'd0;
      alu_opc_q <= 5'd0;
      rd_q      <= 7'd0;
      rs_q      <= 32'd0;
      rsi_q     <= 32'd0;
      rt_q      <= 32'd0;
    end else if (flush) begin
      alu_opc_q <= OPC_NOP;
    end else if (accept) begin
      opc_q     <= bus.in_opcode;
      alu_opc_q <= is_legal(bus.in_opcode) ? bus.in_opcode : OPC_NOP;
      rd_q      <= bus.in_rd;
      rs_q      <= bus.in_rs;
      rsi_q     <= bus.in_rsi;
      rt_q      <= bus.in_rt;
    end else if (retire) begin
      alu_opc_q <= OPC_NOP;
    end
  end

  assign bus.alu_opcode = alu_opc_q;
  assign bus.alu_rd     = {3'b000, rd_q};
  assign bus.alu_rs     = rs_q;
  assign bus.alu_rsi    = rsi_q;
  assign bus.alu_rt     = rt_q;

  assign done      = (state_q == ST_DONE);
  assign illegal   = !is_legal(opc_q);
  assign divzero   = (opc_q == OPC_DIV) && (rt_q == 32'd0);
  assign is_branch = (opc_q == OPC_B) || (opc_q == OPC_BEG);

  // Divide-by-zero overrides the ALU quotient with all ones and still writes back.
  assign bus.out_valid         = done;
  assign bus.out_result        = !done ? 32'd0 : (divzero ? 32'hFFFF_FFFF : bus.alu_result);
  assign bus.out_rd            = done ? bus.alu_rd_out : 7'd0;
  assign bus.out_wren          = done && !illegal && (divzero || bus.alu_wren);
  assign bus.out_branch_taken  = done && is_branch && (bus.alu_branch != 7'd0);
  assign bus.out_branch_target = bus.alu_branch;
  assign bus.out_illegal       = done && illegal;
  assign bus.out_divzero       = done && divzero;

endmodule

// File: tb/tb_ex_sequencer.sv
// tb/tb_ex_sequencer.sv - directed vector bench for ex_sequencer with a reference ALU
module tb_ex_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  ex_sequencer_if bus ();

  ex_sequencer #(.MLT_CYCLES(2), .DIV_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  // Reference combinational ALU placed outside the sequencer.
  always_comb begin
    bus.alu_result = 32'd0;
    bus.alu_branch = 7'd0;
    bus.alu_wren   = 1'b0;
    bus.alu_rd_out = 7'(bus.alu_rd);
    case (bus.alu_opcode)
      5'd1:  begin bus.alu_result = bus.alu_rsi;               bus.alu_wren = 1'b1; end
      5'd2:  begin bus.alu_result = bus.alu_rs * bus.alu_rt;   bus.alu_wren = 1'b1; end
      5'd3:  begin
        bus.alu_result = (bus.alu_rt != 32'd0) ? bus.alu_rs / bus.alu_rt : 32'hDEAD_BEEF;
        bus.alu_wren   = 1'b1;
      end
      5'd4:  begin bus.alu_result = bus.alu_rs - bus.alu_rt;   bus.alu_wren = 1'b1; end
      5'd5:  begin bus.alu_result = bus.alu_rs + bus.alu_rt;   bus.alu_wren = 1'b1; end
      5'd6:  begin bus.alu_result = bus.alu_rs;                bus.alu_wren = 1'b1; end
      5'd7:  bus.alu_branch = bus.alu_rt[6:0];
      5'd8:  bus.alu_branch = (bus.alu_rs == bus.alu_rsi) ? bus.alu_rt[6:0] : 7'd0;
      5'd9:  begin bus.alu_result = bus.alu_rs >> bus.alu_rt[4:0]; bus.alu_wren = 1'b1; end
      5'd10: begin bus.alu_result = bus.alu_rsi;               bus.alu_wren = 1'b1; end
      default: ;
    endcase
  end

  typedef struct {
    logic [4:0]  opc;
    logic [6:0]  rd;
    logic [31:0] rs;
    logic [31:0] rsi;
    logic [31:0] rt;
    int          lat;
    logic [31:0] res;
    logic        wren;
    logic        taken;
    logic [6:0]  tgt;
    logic        ill;
    logic        dz;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [4:0] opc, logic [6:0] rd, logic [31:0] rs, logic [31:0] rsi,
                              logic [31:0] rt, int lat, logic [31:0] res, logic wren,
                              logic taken, logic [6:0] tgt, logic ill, logic dz);
    vec_t v;
    v.opc = opc; v.rd = rd; v.rs = rs; v.rsi = rsi; v.rt = rt; v.lat = lat; v.res = res;
    v.wren = wren; v.taken = taken; v.tgt = tgt; v.ill = ill; v.dz = dz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] opc, input logic [6:0] rd, input logic [31:0] rs,
                           input logic [31:0] rsi, input logic [31:0] rt);
    bus.in_opcode = opc;
    bus.in_rd     = rd;
    bus.in_rs     = rs;
    bus.in_rsi    = rsi;
    bus.in_rt     = rt;
  endtask

  // Presents one instruction for the accept edge and leaves the bench in cycle 1.
  task automatic issue(input logic [4:0] opc, input logic [6:0] rd, input logic [31:0] rs,
                       input logic [31:0] rsi, input logic [31:0] rt);
    set_instr(opc, rd, rs, rsi, rt);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [4:0] exp_aop;

    vecs[0]  = mk(5'd5,  7'd5,   32'd3,     32'd0,      32'd4,    1, 32'd7,          1, 0, 7'h00, 0, 0);
    vecs[1]  = mk(5'd3,  7'd2,   32'd100,   32'd0,      32'd7,    8, 32'd14,         1, 0, 7'h00, 0, 0);
    vecs[2]  = mk(5'd3,  7'd3,   32'd55,    32'd0,      32'd0,    8, 32'hFFFF_FFFF,  1, 0, 7'h00, 0, 1);
    vecs[3]  = mk(5'd2,  7'd4,   32'd6,     32'd0,      32'd7,    2, 32'd42,         1, 0, 7'h00, 0, 0);
    vecs[4]  = mk(5'd8,  7'd9,   32'd2,     32'd2,      32'h21,   1, 32'd0,          0, 1, 7'h21, 0, 0);
    vecs[5]  = mk(5'd13, 7'd1,   32'd3,     32'd0,      32'd4,    1, 32'd0,          0, 0, 7'h00, 1, 0);
    vecs[6]  = mk(5'd1,  7'd10,  32'd0,     32'h1234,   32'd0,    1, 32'h1234,       1, 0, 7'h00, 0, 0);
    vecs[7]  = mk(5'd4,  7'd11,  32'd10,    32'd0,      32'd3,    1, 32'd7,          1, 0, 7'h00, 0, 0);
    vecs[8]  = mk(5'd7,  7'd0,   32'd0,     32'd0,      32'h7F,   1, 32'd0,          0, 1, 7'h7F, 0, 0);
    vecs[9]  = mk(5'd8,  7'd6,   32'd1,     32'd2,      32'h15,   1, 32'd0,          0, 0, 7'h00, 0, 0);
    vecs[10] = mk(5'd9,  7'd12,  32'h80,    32'd0,      32'd3,    1, 32'h10,         1, 0, 7'h00, 0, 0);
    vecs[11] = mk(5'd31, 7'd7,   32'd5,     32'd0,      32'd5,    1, 32'd0,          0, 0, 7'h00, 1, 0);
    vecs[12] = mk(5'd6,  7'd127, 32'hCAFEF00D, 32'd0,   32'd0,    1, 32'hCAFEF00D,   1, 0, 7'h00, 0, 0);
    vecs[13] = mk(5'd10, 7'd8,   32'd0,     32'h55,     32'd0,    1, 32'h55,         1, 0, 7'h00, 0, 0);
    vecs[14] = mk(5'd0,  7'd3,   32'd9,     32'd9,      32'd9,    1, 32'd0,          0, 0, 7'h00, 0, 0);
    vecs[15] = mk(5'd7,  7'd1,   32'd0,     32'd0,      32'h80,   1, 32'd0,          0, 0, 7'h00, 0, 0);

    // Reset state, with in_valid asserted to show nothing is offered as ready.
    rst_n = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_instr(5'd5, 7'd9, 32'h11, 32'h22, 32'h33);
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_alu_opcode", bus.alu_opcode, 0);
    chk("rst_alu_rs", bus.alu_rs, 0);
    chk("rst_flags", {bus.out_illegal, bus.out_divzero, bus.out_branch_taken}, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_alu_opcode", bus.alu_opcode, 0);

    // Table: one instruction per vector, latency and every writeback field.
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
      issue(vecs[i].opc, vecs[i].rd, vecs[i].rs, vecs[i].rsi, vecs[i].rt);
      wait_valid(lat);
      exp_aop = (vecs[i].opc > 5'd10) ? 5'd0 : vecs[i].opc;
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), bus.out_result, vecs[i].res);
      chk($sformatf("v%0d_rd", i), bus.out_rd, vecs[i].rd);
      chk($sformatf("v%0d_wren", i), bus.out_wren, vecs[i].wren);
      chk($sformatf("v%0d_taken", i), bus.out_branch_taken, vecs[i].taken);
      chk($sformatf("v%0d_target", i), bus.out_branch_target, vecs[i].tgt);
      chk($sformatf("v%0d_illegal", i), bus.out_illegal, vecs[i].ill);
      chk($sformatf("v%0d_divzero", i), bus.out_divzero, vecs[i].dz);
      chk($sformatf("v%0d_alu_opcode", i), bus.alu_opcode, exp_aop);
      chk($sformatf("v%0d_alu_rd", i), bus.alu_rd, {3'b000, vecs[i].rd});
      tick();
      chk($sformatf("v%0d_retired", i), bus.out_valid, 0);
      chk($sformatf("v%0d_idle_nop", i), bus.alu_opcode, 0);
    end

    // DIV: in_ready low through cycles 1..7, result in cycle 8.
    issue(5'd3, 7'd4, 32'd200, 32'd0, 32'd9);
    for (int c = 1; c < 8; c++) begin
      chk($sformatf("div_c%0d_in_ready", c), bus.in_ready, 0);
      chk($sformatf("div_c%0d_out_valid", c), bus.out_valid, 0);
      tick();
    end
    chk("div_c8_out_valid", bus.out_valid, 1);
    chk("div_c8_result", bus.out_result, 22);
    tick();

    // Stall for 3 cycles in DONE, then back-to-back SUMs retiring every edge.
    bus.out_ready = 1'b0;
    issue(5'd5, 7'd20, 32'd0, 32'd0, 32'd1);
    set_instr(5'd5, 7'd21, 32'd10, 32'd0, 32'd2);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_valid", c), bus.out_valid, 1);
      chk($sformatf("stall%0d_result", c), bus.out_result, 1);
      chk($sformatf("stall%0d_rd", c), bus.out_rd, 20);
      chk($sformatf("stall%0d_in_ready", c), bus.in_ready, 0);
      tick();
    end
    chk("stall_end_result", bus.out_result, 1);
    bus.out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("b2b%0d_valid", k), bus.out_valid, 1);
      chk($sformatf("b2b%0d_result", k), bus.out_result, 11 * k + 1);
      chk($sformatf("b2b%0d_rd", k), bus.out_rd, 20 + k);
      if (k < 3) set_instr(5'd5, 7'(21 + k), 32'(10 * (k + 1)), 32'd0, 32'(k + 2));
      else bus.in_valid = 1'b0;
    end
    tick();
    chk("b2b_idle", bus.out_valid, 0);

    // Flush in cycle 3 of a DIV, with a competing instruction offered.
    issue(5'd3, 7'd5, 32'd50, 32'd0, 32'd5);
    tick();
    tick();
    flush = 1'b1;
    set_instr(5'd5, 7'd6, 32'd1, 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    chk("flush_in_ready", bus.in_ready, 0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_alu_opcode", bus.alu_opcode, 0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid) pulses++;
      tick();
    end
    chk("flush_no_pulse", pulses, 0);
    issue(5'd5, 7'd7, 32'd2, 32'd0, 32'd2);
    wait_valid(lat);
    chk("post_flush_latency", lat, 1);
    chk("post_flush_result", bus.out_result, 4);

    // Flush in DONE with out_ready=1 and in_valid=1: neither retire nor accept.
    flush = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_done_out_valid", bus.out_valid, 0);

    // Reset asserted mid-MLT.
    issue(5'd2, 7'd3, 32'd3, 32'd0, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_mlt_out_valid", bus.out_valid, 0);
    chk("rst_mlt_in_ready", bus.in_ready, 0);
    chk("rst_mlt_alu_opcode", bus.alu_opcode, 0);
    chk("rst_mlt_alu_rt", bus.alu_rt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.out_valid) pulses++;
      tick();
    end
    chk("rst_mlt_no_pulse", pulses, 0);
    set_instr(5'd5, 7'd8, 32'd5, 32'd0, 32'd6);
    bus.in_valid = 1'b1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_result", bus.out_result, 11);
    chk("post_rst_wren", bus.out_wren, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
